// File: rtl/kyber_pkg.sv
// Shared constants, state encoding and small helpers for the CBD sequencer.
package kyber_pkg;

  localparam int KYBER_N    = 256;
  localparam int COEF_W     = 3;
  localparam int BUF_W      = 1536;
  localparam int COEF_VEC_W = KYBER_N * COEF_W;
  localparam int NW_ETA2    = 16;
  localparam int NW_ETA3    = 24;
  localparam int WCNT_W     = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CONV = 2'd2,
    ST_OUT  = 2'd3
  } state_t;

  // Only eta = 2 and eta = 3 have a defined sampler.
  function automatic logic eta_legal(input logic [1:0] eta);
    return (eta == 2'd2) || (eta == 2'd3);
  endfunction

  // Index of the final input word for a given eta.
  function automatic logic [WCNT_W-1:0] word_last(input logic [1:0] eta);
    return (eta == 2'd3) ? WCNT_W'(NW_ETA3 - 1) : WCNT_W'(NW_ETA2 - 1);
  endfunction

endpackage

// File: rtl/cbd.sv
// Combinational centered-binomial sampler. Coefficient i is the difference of
// two eta-bit popcounts taken from consecutive bits of the byte stream (bit 0
// of byte 0 first), emitted as a 3-bit two's-complement value in [-3, 3].
module cbd
  import kyber_pkg::*;
(
  input  logic [BUF_W-1:0]      i_buf,
  input  logic [1:0]            i_eta,
  output logic [COEF_VEC_W-1:0] o_coeffs
);

  logic [2:0] sum_a;
  logic [2:0] sum_b;

  // Per-coefficient popcount difference; eta = 3 uses 6 bits, otherwise 4.
  always_comb begin
    o_coeffs = '0;
    sum_a    = '0;
    sum_b    = '0;
    for (int i = 0; i < KYBER_N; i++) begin
      if (i_eta == 2'd3) begin
        sum_a = {2'b00, i_buf[6*i]}   + {2'b00, i_buf[6*i+1]} + {2'b00, i_buf[6*i+2]};
        sum_b = {2'b00, i_buf[6*i+3]} + {2'b00, i_buf[6*i+4]} + {2'b00, i_buf[6*i+5]};
      end else begin
        sum_a = {2'b00, i_buf[4*i]}   + {2'b00, i_buf[4*i+1]};
        sum_b = {2'b00, i_buf[4*i+2]} + {2'b00, i_buf[4*i+3]};
      end
      o_coeffs[COEF_W*i +: COEF_W] = sum_a - sum_b;
    end
  end

endmodule

// File: rtl/cbd_ctrl.sv
// Sequencer around cbd: gathers PRF words into a 1536-bit buffer, samples one
// polynomial in a single CONV cycle, then streams the registered coefficients.
// Handshakes: a word moves when i_in_valid & o_in_ready at a rising edge, a
// beat moves when o_out_valid & i_out_ready at a rising edge; valid never
// depends on ready, and o_out_data is held while a beat waits for ready.
module cbd_ctrl
  import kyber_pkg::*;
#(
  parameter int BW_IN     = 64,
  parameter int NCOEF_OUT = 8
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_start,
  input  logic [1:0]                  i_eta,
  input  logic                        i_in_valid,
  input  logic [BW_IN-1:0]            i_in_data,
  output logic                        o_in_ready,
  output logic                        o_out_valid,
  output logic [COEF_W*NCOEF_OUT-1:0] o_out_data,
  input  logic                        i_out_ready,
  output logic                        o_busy,
  output logic                        o_done,
  output logic                        o_err,
  output state_t                      o_state
);

  localparam int OUT_W  = COEF_W * NCOEF_OUT;
  localparam int NBEAT  = KYBER_N / NCOEF_OUT;
  localparam int BEAT_W = (NBEAT > 1) ? $clog2(NBEAT) : 1;
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(NBEAT - 1);

  state_t                  state;
  state_t                  state_nxt;
  logic [1:0]              eta_q;
  logic [WCNT_W-1:0]       word_cnt;
  logic [BEAT_W-1:0]       beat_cnt;
  logic [BUF_W-1:0]        buf_q;
  logic [COEF_VEC_W-1:0]   coef_q;
  logic [COEF_VEC_W-1:0]   coeffs;
  logic                    done_q;
  logic                    err_q;

  logic                    in_ready;
  logic                    out_valid;
  logic                    start_ok;
  logic                    start_bad;
  logic                    word_fire;
  logic                    beat_fire;
  logic                    last_word;
  logic                    last_beat;

  assign last_word = (word_cnt == word_last(eta_q));
  assign last_beat = (beat_cnt == BEAT_LAST);
  assign word_fire = in_ready & i_in_valid;
  assign beat_fire = out_valid & i_out_ready;

  cbd u_cbd (
    .i_buf    (buf_q),
    .i_eta    (eta_q),
    .o_coeffs (coeffs)
  );

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state and handshake decode; start is only looked at in IDLE.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    start_ok  = 1'b0;
    start_bad = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_start) begin
          if (eta_legal(i_eta)) begin
            start_ok  = 1'b1;
            state_nxt = ST_LOAD;
          end else begin
            start_bad = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        in_ready = 1'b1;
        if (i_in_valid && last_word) state_nxt = ST_CONV;
      end
      ST_CONV: state_nxt = ST_OUT;
      ST_OUT: begin
        out_valid = 1'b1;
        if (i_out_ready && last_beat) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Latched eta, saturating counters and the one-cycle done/err pulses.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      eta_q    <= '0;
      word_cnt <= '0;
      beat_cnt <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= beat_fire & last_beat;
      err_q  <= start_bad;
      if (start_ok) begin
        eta_q    <= i_eta;
        word_cnt <= '0;
      end else if (word_fire && !last_word) begin
        word_cnt <= word_cnt + 1'b1;
      end
      if (state == ST_CONV) begin
        beat_cnt <= '0;
      end else if (beat_fire && !last_beat) begin
        beat_cnt <= beat_cnt + 1'b1;
      end
    end
  end

  // Input buffer: wiped on start so bytes past the eta=2 range read as zero.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      buf_q <= '0;
    end else if (start_ok) begin
      buf_q <= '0;
    end else if (word_fire) begin
      buf_q[word_cnt*BW_IN +: BW_IN] <= i_in_data;
    end
  end

  // Coefficient register captures the sampler output during CONV.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                  coef_q <= '0;
    else if (state == ST_CONV)  coef_q <= coeffs;
  end

  assign o_in_ready  = in_ready;
  assign o_out_valid = out_valid;
  assign o_out_data  = out_valid ? coef_q[beat_cnt*OUT_W +: OUT_W] : '0;
  assign o_busy      = (state != ST_IDLE);
  assign o_done      = done_q;
  assign o_err       = err_q;
  assign o_state     = state;

endmodule
